// File: rtl/seg7_pkg.sv
// Shared types and constants for the serial 7-segment driver.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active low.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } seg7_state_e;

    localparam int         FRAME_BITS = 64;
    localparam logic [7:0] BLANK_BYTE = 8'hFF;

    // Index 0 is the rightmost entry; every entry has the dp bit off.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp);
        return {~dp, HEX_SEG[nib][6:0]};
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble plus decimal-point request to one active-low segment byte.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = hex_to_seg(nibble, dp);

endmodule

// File: rtl/seg7_serial_driver.sv
// Periodically decodes an 8-digit hex value and shifts the 64-bit segment
// frame into the board's 7-segment shift-register chain, then latches it.
//
// state | meaning
// IDLE  | waiting for a refresh tick (live or pending)
// LOAD  | one cycle: snapshot inputs and blink phase into the frame register
// SHIFT | 64 bits out MSB first, CLK_DIV cycles low then CLK_DIV cycles high
// LATCH | seg_pen high for CLK_DIV cycles
module seg7_serial_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLINK_BITS     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic [7:0]  le,
    input  logic [7:0]  point,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    seg7_state_e state_q, state_d;

    logic [REF_W-1:0]      ref_cnt_q;
    logic                  tick;
    logic                  pending_q;
    logic                  take;
    logic [BLINK_BITS-1:0] blink_q;
    logic [DIV_W-1:0]      div_q;
    logic                  div_done;
    logic                  half_q;
    logic [BIT_W-1:0]      bit_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic [7:0][7:0]       dec_byte;
    logic                  clrn_q;
    logic                  blink_phase;

    // Refresh timer: down-counter whose terminal count is the tick.
    assign tick = (ref_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt_q <= REF_LAST;
            blink_q   <= '0;
            pending_q <= 1'b0;
            clrn_q    <= 1'b0;
        end else begin
            ref_cnt_q <= tick ? REF_LAST : ref_cnt_q - REF_W'(1);
            blink_q   <= blink_q + BLINK_BITS'(1);
            clrn_q    <= 1'b1;
            if (take) begin
                pending_q <= 1'b0;
            end else if (tick) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign blink_phase = blink_q[BLINK_BITS-1];

    for (genvar i = 0; i < 8; i++) begin : g_digit
        seg7_hex_decode u_dec (
            .nibble (disp_num[4*i +: 4]),
            .dp     (point[i]),
            .seg    (dec_byte[i])
        );
        assign frame_d[8*i +: 8] = (le[i] && blink_phase) ? BLANK_BYTE : dec_byte[i];
    end

    assign div_done = (div_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        seg_clk  = 1'b0;
        seg_sout = 1'b1;
        seg_pen  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q || tick) begin
                    state_d = LOAD;
                    take    = 1'b1;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                seg_clk  = half_q;
                seg_sout = frame_q[FRAME_BITS-1];
                if (div_done && half_q && (bit_q == BIT_LAST)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                busy    = 1'b1;
                seg_pen = 1'b1;
                if (div_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The frame only moves at the end of a high phase, so seg_sout is
    // stable across the whole seg_clk period around the sampling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            frame_q <= '1;
        end else begin
            case (state_q)
                LOAD: begin
                    frame_q <= frame_d;
                    div_q   <= DIV_LAST;
                    half_q  <= 1'b0;
                    bit_q   <= '0;
                end
                SHIFT: begin
                    if (div_done) begin
                        div_q  <= DIV_LAST;
                        half_q <= ~half_q;
                        if (half_q) begin
                            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b1};
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (!div_done) begin
                        div_q <= div_q - DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign seg_clrn = clrn_q;

endmodule

// File: tb/tb_seg7_serial_driver.sv
// Bench for seg7_serial_driver: two instances (refresh 400 and a backed-up
// refresh of 100) checked every cycle against a frame-schedule model.
module tb_seg7_serial_driver;

    localparam int R_A  = 400;
    localparam int R_B  = 100;
    localparam int FLEN = 130;
    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rst, rst2;
    logic [31:0] disp_num;
    logic [7:0]  le, point;
    logic [31:0] disp_b;
    logic [7:0]  le_b, point_b;
    logic seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a, busy_a;
    logic seg_clk_b, seg_sout_b, seg_pen_b, seg_clrn_b, busy_b;

    int checks = 0;
    int errors = 0;

    int cyc_a = 0, cyc_b = 0;
    logic [63:0] fr_a = '0, fr_b = '0, cap_a = '0, cap_b = '0, last_a = '0;
    int rises_a = 0, rises_b = 0, frames_done_a = 0, pen_cyc_a = 0, nb = 0;
    logic pclk_a = 1'b0, ppen_a = 1'b0, pclk_b = 1'b0, ppen_b = 1'b0;
    logic [63:0] b_frames [8];
    int b_pen [8];

    seg7_serial_driver #(.CLK_DIV(1), .REFRESH_CYCLES(R_A), .BLINK_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .disp_num(disp_num), .le(le), .point(point),
        .seg_clk(seg_clk_a), .seg_sout(seg_sout_a), .seg_pen(seg_pen_a),
        .seg_clrn(seg_clrn_a), .busy(busy_a)
    );

    seg7_serial_driver #(.CLK_DIV(1), .REFRESH_CYCLES(R_B), .BLINK_BITS(4)) dut_b (
        .clk(clk), .rst(rst2), .disp_num(disp_b), .le(le_b), .point(point_b),
        .seg_clk(seg_clk_b), .seg_sout(seg_sout_b), .seg_pen(seg_pen_b),
        .seg_clrn(seg_clrn_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc_a <= 0;
        else      cyc_a <= cyc_a + 1;
    end

    always @(posedge clk or negedge rst2) begin
        if (!rst2) cyc_b <= 0;
        else       cyc_b <= cyc_b + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_frame(input logic [31:0] n, input logic [7:0] l,
                                                input logic [7:0] p, input logic ph);
        logic [63:0] f;
        logic [7:0]  b;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            b = SEG_TBL[n[4*i +: 4]];
            if (p[i]) b = b & 8'h7F;
            if (l[i] && ph) b = 8'hFF;
            f[8*i +: 8] = b;
        end
        return f;
    endfunction

    // o = cycles since the frame's LOAD cycle, -1 when no frame has started.
    task automatic chk_cycle(input string tag, input logic rv, input int cycv, input int o,
                             input logic [63:0] fr, input logic sclk, input logic sout,
                             input logic pen, input logic clrn, input logic bsy);
        logic [3:0] e;
        logic       e_sout, do_sout;
        e_sout  = 1'b1;
        do_sout = 1'b1;
        if (!rv) begin
            e = 4'b0000;
        end else if (o < 0 || o > FLEN - 1) begin
            e = {3'b000, cycv > 0};
        end else if (o == 0) begin
            e = 4'b0011;
            do_sout = 1'b0;
        end else if (o <= 128) begin
            e = {((o - 1) % 2) == 1, 3'b011};
            e_sout = fr[63 - (o - 1) / 2];
        end else begin
            e = 4'b0111;
            do_sout = 1'b0;
        end
        chk({tag, " clk/pen/busy/clrn"}, {60'd0, sclk, pen, bsy, clrn}, {60'd0, e});
        if (do_sout) chk({tag, " sout"}, {63'd0, sout}, {63'd0, e_sout});
    endtask

    always @(negedge clk) begin : cmp_a
        int o;
        o = (rst && cyc_a >= R_A) ? cyc_a % R_A : -1;
        if (o == 0) fr_a = model_frame(disp_num, le, point, (cyc_a % 16) >= 8);
        chk_cycle("A", rst, cyc_a, o, fr_a, seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a, busy_a);
        if (!rst) begin
            rises_a = 0; pclk_a = 1'b0; ppen_a = 1'b0;
        end else begin
            if (seg_clk_a && !pclk_a) begin
                cap_a = {cap_a[62:0], seg_sout_a};
                rises_a++;
            end
            if (seg_pen_a && !ppen_a) begin
                chk("A seg_clk rises", 64'(rises_a), 64'd64);
                chk("A frame vs model", cap_a, fr_a);
                last_a = cap_a;
                pen_cyc_a = cyc_a;
                frames_done_a++;
                rises_a = 0;
            end
            pclk_a = seg_clk_a;
            ppen_a = seg_pen_a;
        end
    end

    always @(negedge clk) begin : cmp_b
        int o;
        o = (rst2 && cyc_b >= R_B) ? (cyc_b - R_B) % (FLEN + 1) : -1;
        if (o == 0) fr_b = model_frame(disp_b, le_b, point_b, (cyc_b % 16) >= 8);
        chk_cycle("B", rst2, cyc_b, o, fr_b, seg_clk_b, seg_sout_b, seg_pen_b, seg_clrn_b, busy_b);
        if (!rst2) begin
            rises_b = 0; pclk_b = 1'b0; ppen_b = 1'b0;
        end else begin
            if (seg_clk_b && !pclk_b) begin
                cap_b = {cap_b[62:0], seg_sout_b};
                rises_b++;
            end
            if (seg_pen_b && !ppen_b) begin
                chk("B seg_clk rises", 64'(rises_b), 64'd64);
                chk("B frame vs model", cap_b, fr_b);
                if (nb < 8) begin
                    b_frames[nb] = cap_b;
                    b_pen[nb] = cyc_b;
                end
                nb++;
                rises_b = 0;
            end
            pclk_b = seg_clk_b;
            ppen_b = seg_pen_b;
        end
    end

    task automatic wait_frame_a(input int budget);
        int start;
        bit seen;
        start = frames_done_a;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (frames_done_a != start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame timeout actual=none required=seg_pen within %0d cycles", budget);
        end
    endtask

    task automatic wait_busy_a(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (busy_a) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy timeout actual=0 required=1 within %0d cycles", budget);
        end
    endtask

    initial begin
        int pens_before;
        rst = 1'b0; rst2 = 1'b0;
        disp_num = 32'h0123ABCD; le = 8'h00; point = 8'h00;
        disp_b = 32'h11111111; le_b = 8'h80; point_b = 8'h00;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1; rst2 = 1'b1;

        // Plain hex frame and first-frame timing.
        wait_frame_a(700);
        chk("hex frame", last_a, 64'hC0F9A4B08883C6A1);
        chk("first pen cycle", 64'(pen_cyc_a), 64'd529);
        #2;
        disp_num = 32'h88888888; point = 8'h01;

        // Decimal point; inputs changed mid-SHIFT must not reach this frame.
        wait_busy_a(500);
        repeat (10) @(posedge clk);
        #2;
        disp_num = 32'hFFFFFFFF; point = 8'h00;
        wait_frame_a(300);
        chk("dp frame", last_a, 64'h8080808080808000);
        chk("dp last byte", {56'd0, last_a[7:0]}, 64'h00);
        wait_frame_a(600);
        chk("frame after change", last_a, 64'h8E8E8E8E8E8E8E8E);
        #2;
        disp_num = 32'h76543210;

        // Reset while shifting bit 30.
        wait_busy_a(500);
        repeat (61) @(posedge clk);
        #1;
        chk("busy before reset", {63'd0, busy_a}, 64'd1);
        pens_before = frames_done_a;
        rst = 1'b0;
        #1;
        chk("async rst seg_clk", {63'd0, seg_clk_a}, 64'd0);
        chk("async rst seg_sout", {63'd0, seg_sout_a}, 64'd1);
        chk("async rst seg_pen", {63'd0, seg_pen_a}, 64'd0);
        chk("async rst seg_clrn", {63'd0, seg_clrn_a}, 64'd0);
        chk("async rst busy", {63'd0, busy_a}, 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_frame_a(700);
        chk("pens after reset", 64'(frames_done_a), 64'(pens_before + 1));
        chk("frame after reset", last_a, 64'hF8829299B0A4F9C0);
        chk("pen cycle after reset", 64'(pen_cyc_a), 64'd529);

        // Backed-up refresh instance: back-to-back frames and blink phase.
        chk("B frames seen", {63'd0, nb >= 5}, 64'd1);
        chk("B frame0", b_frames[0], 64'hF9F9F9F9F9F9F9F9);
        chk("B frame1", b_frames[1], 64'hF9F9F9F9F9F9F9F9);
        chk("B frame2 blank", b_frames[2], 64'hFFF9F9F9F9F9F9F9);
        chk("B frame3 blank", b_frames[3], 64'hFFF9F9F9F9F9F9F9);
        chk("B frame4", b_frames[4], 64'hF9F9F9F9F9F9F9F9);
        chk("B pen0 cycle", 64'(b_pen[0]), 64'd229);
        chk("B pen1 cycle", 64'(b_pen[1]), 64'd360);
        chk("B pen2 cycle", 64'(b_pen[2]), 64'd491);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_serial_driver.md
Name: seg7_serial_driver

Overview:
- Consumes the display multiplexer's selected 32-bit number, per-digit blink mask and per-digit decimal-point mask.
- Hex-decodes the eight nibbles into active-low segment bytes and applies blink and decimal point.
- Shifts the resulting 64-bit frame serially into the board's 7-segment shift-register chain, then pulses the latch.
- Refreshes the display periodically from a free-running counter.

Parameters:
- CLK_DIV, 2: clk cycles per seg_clk half-period; must be >= 1.
- REFRESH_CYCLES, 50000: clk cycles between frame starts; must be greater than the frame length.
- BLINK_BITS, 24: width of the blink counter; blink phase is the counter MSB.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- disp_num  in  32  number to display; digit i = disp_num[4i+3:4i], digit 7 leftmost.
- le  in  8  blink enable per digit; 1 = digit i blinks.
- point  in  8  decimal point per digit; 1 = point lit.
- seg_clk  out  1  shift clock to the chain; chain samples on rising edge.
- seg_sout  out  1  serial data, stable for the whole seg_clk period.
- seg_pen  out  1  latch pulse; active high.
- seg_clrn  out  1  chain clear; active low.
- busy  out  1  high from LOAD through LATCH.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: seg_clk=0, seg_sout=1, seg_pen=0, seg_clrn=0, busy=0.
  - FSM returns to IDLE; refresh counter, blink counter, bit counter, divider and pending flag clear.
- After reset release: seg_clrn=1 from the first clk edge on and stays 1.
- Refresh counter:
  - Free-running 0..REFRESH_CYCLES-1 and wraps.
  - Reaching REFRESH_CYCLES-1 sets the one-deep pending flag; a second tick while pending is dropped.
- Blink counter: free-running BLINK_BITS wide, wraps; phase = MSB.
- FSM states:
  - IDLE: if pending, clear pending and go to LOAD.
  - LOAD: one cycle.
    - Snapshot disp_num, le, point and phase.
    - Build frame byte i = hex(digit i) with bit7 = ~point[i].
    - If le[i]=1 and phase=1, byte i is forced to 8'hFF (digit blank, point off).
    - Frame = {byte7..byte0}. Go to SHIFT.
  - SHIFT: 64 bits, MSB of byte7 first, LSB of byte0 last.
    - Each bit holds seg_sout for CLK_DIV cycles with seg_clk=0, then CLK_DIV cycles with seg_clk=1.
    - After the 64th high phase, seg_clk returns to 0 and the FSM goes to LATCH.
  - LATCH: seg_pen=1 for CLK_DIV cycles, then back to IDLE; seg_sout returns to 1.
- Byte format {dp,g,f,e,d,c,b,a}, active low. Hex 0-F (dp off) = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- Input changes during SHIFT/LATCH have no effect until the next LOAD.
- Timing:
  - Frame length = 1 + 128*CLK_DIV + CLK_DIV cycles.
  - First seg_clk rise occurs CLK_DIV cycles after the first SHIFT cycle.
  - LOAD follows the tick cycle by 1 cycle, or by 2 cycles if the tick lands in the last LATCH cycle.
- Reset mid-frame: frame abandoned immediately; no seg_pen pulse; first frame after release follows the first refresh tick.
- busy=1 exactly during LOAD, SHIFT and LATCH.

Decomposition:
- Shared package seg7_pkg:
  - FSM state enum (IDLE, LOAD, SHIFT, LATCH).
  - Hex-to-segment constant table.
  - BLANK_BYTE = 8'hFF.
  - FRAME_BITS = 64.
- Sub-module seg7_hex_decode: combinational 4-bit nibble plus dp bit to 8-bit active-low segment byte. Instantiated 8 times in LOAD datapath.

Test Plan:
- Bench parameters: CLK_DIV=1, REFRESH_CYCLES=400, BLINK_BITS=4.
- Reset: rst=0 for 5 cycles, then release. Expect seg_clrn=0 while rst=0 and 1 afterwards; no seg_pen before cycle 399; first LOAD at the cycle after the tick.
- Hex frame: disp_num=32'h0123ABCD, le=0, point=0. Bench shift register captures on seg_clk rise. After the seg_pen pulse expect 64'hC0F9A4B08883C6A1, with exactly 64 seg_clk rises.
- Decimal point: disp_num=32'h88888888, point=8'h01, le=0. Expect the last captured byte = 8'h00 and the other bytes = 8'h80.
- Blink: disp_num=32'h11111111, le=8'h80. Frames with phase=1 expect byte7=8'hFF; frames with phase=0 expect byte7=8'hF9; bytes 6..0 always 8'hF9.
- Mid-frame reset: assert rst at bit 30 of SHIFT. Expect outputs return to their reset values asynchronously and busy=0; no seg_pen pulse; the next frame is complete and correct.
- Snapshot and pending tick:
  - Change disp_num during SHIFT; the frame must still carry the old value, and the next frame the new one.
  - With REFRESH_CYCLES=100 (below the frame length of 130), ticks back up. Expect back-to-back frames separated by exactly one IDLE cycle, with no third frame queued.
